// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_arb_pkg
// Purpose : Shared types and constants for the I/D memory arbiter.
//           arb_state_t - arbiter FSM state encoding
//           gnt_id_t    - identifies the requester that holds the memory
// Revision: 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_BUSY_I = 2'd1,
      ARB_BUSY_D = 2'd2
   } arb_state_t;

   typedef logic gnt_id_t;

   localparam gnt_id_t GNT_I = 1'b0;
   localparam gnt_id_t GNT_D = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mem_arb_pick.sv
`default_nettype none
// ============================================================================
// Module  : mem_arb_pick
// Purpose : Combinational grant selector for the memory arbiter.
//           MEM_ARB_RR_EN undefined : fixed priority, D over I.
//           MEM_ARB_RR_EN defined   : on a tie, grant the requester that was
//                                     not granted last.
// Ports   : i_elig    in  fetch requester eligible this cycle
//           d_elig    in  load/store requester eligible this cycle
//           last_gnt  in  previous grant (only with MEM_ARB_RR_EN)
//           gnt_valid out at least one requester eligible
//           gnt_id    out selected requester (GNT_I / GNT_D)
// Revision: 1.0 - initial release
// ============================================================================
module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic    i_elig,
   input  logic    d_elig,
`ifdef MEM_ARB_RR_EN
   input  gnt_id_t last_gnt,
`endif
   output logic    gnt_valid,
   output gnt_id_t gnt_id
);

   always_comb begin
      gnt_valid = i_elig | d_elig;
      gnt_id    = GNT_I;
`ifdef MEM_ARB_RR_EN
      if (i_elig && d_elig) begin
         gnt_id = (last_gnt == GNT_I) ? GNT_D : GNT_I;
      end else if (d_elig) begin
         gnt_id = GNT_D;
      end
`else
      // The load/store belongs to the older instruction, so it goes first.
      if (d_elig) begin
         gnt_id = GNT_D;
      end
`endif
   end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_arbiter
// Purpose : Shares one single-ported memory between instruction fetch (I)
//           and load/store (D). One transaction at a time; memory request is
//           held until mem_ready, then the owner gets a one-cycle ack.
//           Optional macro MEM_ARB_RR_EN selects round-robin tie breaking.
// Ports   : clk, rst (async, active high)
//           i_req/i_addr -> i_ack/i_rdata          fetch port
//           d_req/d_we/d_addr/d_wdata -> d_ack/d_rdata   data port
//           mem_req/mem_we/mem_addr/mem_wdata -> memory
//           mem_ready/mem_rdata <- memory
//           stall  : a request is pending and not yet acknowledged
// Revision: 1.0 - initial release
// ============================================================================
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_ack,
   output logic [DATA_W-1:0] i_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ack,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              stall
);

   arb_state_t        state_q,     state_d;
   logic              i_ack_q,     i_ack_d;
   logic              d_ack_q,     d_ack_d;
   logic              mem_req_q,   mem_req_d;
   logic              mem_we_q,    mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0] i_rdata_q,   i_rdata_d;
   logic [DATA_W-1:0] d_rdata_q,   d_rdata_d;
`ifdef MEM_ARB_RR_EN
   gnt_id_t           last_gnt_q,  last_gnt_d;
`endif

   // A requester being acked this cycle still shows req high; it must not
   // be granted again until the following cycle.
   logic    i_elig, d_elig, gnt_valid;
   gnt_id_t gnt_id;

   assign i_elig = i_req & ~i_ack_q;
   assign d_elig = d_req & ~d_ack_q;

   mem_arb_pick u_pick (
      .i_elig    (i_elig),
      .d_elig    (d_elig),
`ifdef MEM_ARB_RR_EN
      .last_gnt  (last_gnt_q),
`endif
      .gnt_valid (gnt_valid),
      .gnt_id    (gnt_id)
   );

   always_comb begin
      state_d     = state_q;
      i_ack_d     = 1'b0;
      d_ack_d     = 1'b0;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      i_rdata_d   = i_rdata_q;
      d_rdata_d   = d_rdata_q;
`ifdef MEM_ARB_RR_EN
      last_gnt_d  = last_gnt_q;
`endif
      case (state_q)
         ARB_IDLE: begin
            if (gnt_valid) begin
               mem_req_d = 1'b1;
`ifdef MEM_ARB_RR_EN
               last_gnt_d = gnt_id;
`endif
               if (gnt_id == GNT_D) begin
                  mem_we_d    = d_we;
                  mem_addr_d  = d_addr;
                  mem_wdata_d = d_wdata;
                  state_d     = ARB_BUSY_D;
               end else begin
                  mem_we_d    = 1'b0;
                  mem_addr_d  = i_addr;
                  mem_wdata_d = '0;
                  state_d     = ARB_BUSY_I;
               end
            end
         end
         ARB_BUSY_I: begin
            if (mem_ready) begin
               i_rdata_d = mem_rdata;
               i_ack_d   = 1'b1;
               mem_req_d = 1'b0;
               state_d   = ARB_IDLE;
            end
         end
         ARB_BUSY_D: begin
            if (mem_ready) begin
               // Stores return nothing; keep the last load data visible.
               if (!mem_we_q) begin
                  d_rdata_d = mem_rdata;
               end
               d_ack_d   = 1'b1;
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
               state_d   = ARB_IDLE;
            end
         end
         default: begin
            state_d   = ARB_IDLE;
            mem_req_d = 1'b0;
            mem_we_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ARB_IDLE;
         i_ack_q     <= 1'b0;
         d_ack_q     <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         i_rdata_q   <= '0;
         d_rdata_q   <= '0;
`ifdef MEM_ARB_RR_EN
         last_gnt_q  <= GNT_I;
`endif
      end else begin
         state_q     <= state_d;
         i_ack_q     <= i_ack_d;
         d_ack_q     <= d_ack_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         i_rdata_q   <= i_rdata_d;
         d_rdata_q   <= d_rdata_d;
`ifdef MEM_ARB_RR_EN
         last_gnt_q  <= last_gnt_d;
`endif
      end
   end

   assign i_ack     = i_ack_q;
   assign d_ack     = d_ack_q;
   assign i_rdata   = i_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign stall     = (i_req & ~i_ack_q) | (d_req & ~d_ack_q);

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_arbiter
// Purpose : Self-checking bench for mem_arbiter. A per-cycle vector table
//           covers fetch, delayed store, tie, back-to-back fetch, reset
//           mid-transaction and stray mem_ready; hand-written sequences
//           cover the tie-break behaviour with and without MEM_ARB_RR_EN.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_req = 1'b0;
   logic [31:0] i_addr = '0;
   logic        i_ack;
   logic [31:0] i_rdata;
   logic        d_req = 1'b0;
   logic        d_we = 1'b0;
   logic [31:0] d_addr = '0;
   logic [31:0] d_wdata = '0;
   logic        d_ack;
   logic [31:0] d_rdata;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ready = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic        stall;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .i_req     (i_req),
      .i_addr    (i_addr),
      .i_ack     (i_ack),
      .i_rdata   (i_rdata),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_ack     (d_ack),
      .d_rdata   (d_rdata),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ready (mem_ready),
      .mem_rdata (mem_rdata),
      .stall     (stall)
   );

   // inb = {rst, i_req, d_req, d_we, mem_ready}
   // exb = {i_ack, d_ack, mem_req, mem_we, stall}
   typedef struct {
      logic [4:0]  inb;
      logic [31:0] iaddr;
      logic [31:0] daddr;
      logic [31:0] dwdata;
      logic [31:0] mrdata;
      logic [4:0]  exb;
      logic [31:0] maddr;
      logic [31:0] mwdata;
      logic [31:0] irdata;
      logic [31:0] drdata;
   } rec_t;

   rec_t tbl[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   localparam logic [31:0] F1 = 32'h8C01_0004;
   localparam logic [31:0] DB = 32'hDEAD_BEEF;
   localparam logic [31:0] XX = 32'h1234_5678;
   localparam logic [31:0] A1 = 32'hAAAA_0001;
   localparam logic [31:0] B2 = 32'hBBBB_0002;
   localparam logic [31:0] R1 = 32'h1111_1111;
   localparam logic [31:0] R2 = 32'h2222_2222;
   localparam logic [31:0] CF = 32'hCAFE_F00D;
   localparam logic [31:0] Z  = 32'h0;

`ifdef MEM_ARB_RR_EN
   localparam logic TIE_AFTER_D_FIRST_D = 1'b0;
`else
   localparam logic TIE_AFTER_D_FIRST_D = 1'b1;
`endif

   function automatic rec_t row(input logic [4:0] inb, input logic [31:0] iaddr,
                                input logic [31:0] daddr, input logic [31:0] dwdata,
                                input logic [31:0] mrdata, input logic [4:0] exb,
                                input logic [31:0] maddr, input logic [31:0] mwdata,
                                input logic [31:0] irdata, input logic [31:0] drdata);
      rec_t r;
      r.inb = inb;     r.iaddr = iaddr;   r.daddr = daddr;   r.dwdata = dwdata;
      r.mrdata = mrdata; r.exb = exb;     r.maddr = maddr;   r.mwdata = mwdata;
      r.irdata = irdata; r.drdata = drdata;
      return r;
   endfunction

   task automatic chk1(input string nm, input int idx, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @%0d: got %b expected %b", nm, idx, act, exp);
      end
   endtask

   task automatic chk32(input string nm, input int idx, input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @%0d: got %h expected %h", nm, idx, act, exp);
      end
   endtask

   task automatic wait_mem_req(input string nm, input int idx);
      int n = 0;
      while (mem_req !== 1'b1 && n < 8) begin
         @(posedge clk); #1;
         n++;
      end
      chk1(nm, idx, mem_req, 1'b1);
   endtask

   // Single load/fetch with immediate mem_ready; leaves the arbiter idle.
   task automatic lone(input logic is_d, input logic [31:0] addr, input logic [31:0] rd,
                       input int idx);
      @(posedge clk); #1;
      if (is_d) begin
         d_req = 1'b1; d_we = 1'b0; d_addr = addr;
      end else begin
         i_req = 1'b1; i_addr = addr;
      end
      @(posedge clk); #1;
      wait_mem_req("lone_req", idx);
      chk32("lone_addr", idx, mem_addr, addr);
      mem_ready = 1'b1; mem_rdata = rd;
      @(posedge clk); #1;
      mem_ready = 1'b0;
      chk1("lone_ack", idx, is_d ? d_ack : i_ack, 1'b1);
      chk32("lone_rdata", idx, is_d ? d_rdata : i_rdata, rd);
      i_req = 1'b0; d_req = 1'b0;
   endtask

   // Both requesters raised in the same idle cycle and held until acked.
   task automatic tie(input logic first_d, input int idx);
      logic [31:0] a_first, a_second;
      a_first  = first_d ? 32'h400 : 32'h300;
      a_second = first_d ? 32'h300 : 32'h400;
      @(posedge clk); #1;
      i_req = 1'b1; i_addr = 32'h300;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400;
      @(posedge clk); #1;
      wait_mem_req("tie_req1", idx);
      chk32("tie_first_addr", idx, mem_addr, a_first);
      mem_ready = 1'b1; mem_rdata = 32'h0F0F_0001;
      @(posedge clk); #1;
      mem_ready = 1'b0;
      chk1("tie_first_ack", idx, first_d ? d_ack : i_ack, 1'b1);
      chk1("tie_other_noack", idx, first_d ? i_ack : d_ack, 1'b0);
      if (first_d) d_req = 1'b0; else i_req = 1'b0;
      @(posedge clk); #1;
      chk1("tie_req2", idx, mem_req, 1'b1);
      chk32("tie_second_addr", idx, mem_addr, a_second);
      mem_ready = 1'b1; mem_rdata = 32'h0F0F_0002;
      @(posedge clk); #1;
      mem_ready = 1'b0;
      chk1("tie_second_ack", idx, first_d ? i_ack : d_ack, 1'b1);
      i_req = 1'b0; d_req = 1'b0;
   endtask

   initial begin
      //             inb       iaddr   daddr   dwdata mrdata exb       maddr   mwdata irdata drdata
      tbl.push_back(row(5'b10000, Z,      Z,      Z,     Z,   5'b00000, Z,      Z,     Z,  Z));  // 0 reset
      tbl.push_back(row(5'b01000, 32'h10, Z,      Z,     Z,   5'b00001, Z,      Z,     Z,  Z));  // 1 fetch
      tbl.push_back(row(5'b01001, 32'h10, Z,      Z,     F1,  5'b00101, 32'h10, Z,     Z,  Z));  // 2
      tbl.push_back(row(5'b01000, 32'h10, Z,      Z,     Z,   5'b10000, Z,      Z,     F1, Z));  // 3 ack
      tbl.push_back(row(5'b00000, Z,      Z,      Z,     Z,   5'b00000, Z,      Z,     F1, Z));  // 4
      tbl.push_back(row(5'b00110, Z,      32'h40, DB,    Z,   5'b00001, Z,      Z,     F1, Z));  // 5 store
      tbl.push_back(row(5'b00110, Z,      32'h40, DB,    Z,   5'b00111, 32'h40, DB,    F1, Z));  // 6
      tbl.push_back(row(5'b00110, Z,      32'h40, DB,    Z,   5'b00111, 32'h40, DB,    F1, Z));  // 7
      tbl.push_back(row(5'b00110, Z,      32'h40, DB,    Z,   5'b00111, 32'h40, DB,    F1, Z));  // 8
      tbl.push_back(row(5'b00111, Z,      32'h40, DB,    XX,  5'b00111, 32'h40, DB,    F1, Z));  // 9
      tbl.push_back(row(5'b00110, Z,      32'h40, DB,    Z,   5'b01000, Z,      Z,     F1, Z));  // 10 d_ack
      tbl.push_back(row(5'b00000, Z,      Z,      Z,     Z,   5'b00000, Z,      Z,     F1, Z));  // 11
      tbl.push_back(row(5'b10000, Z,      Z,      Z,     Z,   5'b00000, Z,      Z,     Z,  Z));  // 12 reset
      tbl.push_back(row(5'b01100, 32'h100,32'h200,Z,     Z,   5'b00001, Z,      Z,     Z,  Z));  // 13 tie
      tbl.push_back(row(5'b01101, 32'h100,32'h200,Z,     A1,  5'b00101, 32'h200,Z,     Z,  Z));  // 14 D first
      tbl.push_back(row(5'b01000, 32'h100,Z,      Z,     Z,   5'b01001, Z,      Z,     Z,  A1)); // 15
      tbl.push_back(row(5'b01001, 32'h100,Z,      Z,     B2,  5'b00101, 32'h100,Z,     Z,  A1)); // 16 I next
      tbl.push_back(row(5'b01000, 32'h100,Z,      Z,     Z,   5'b10000, Z,      Z,     B2, A1)); // 17
      tbl.push_back(row(5'b00000, Z,      Z,      Z,     Z,   5'b00000, Z,      Z,     B2, A1)); // 18
      tbl.push_back(row(5'b01000, 32'h20, Z,      Z,     Z,   5'b00001, Z,      Z,     B2, A1)); // 19 b2b
      tbl.push_back(row(5'b01001, 32'h20, Z,      Z,     R1,  5'b00101, 32'h20, Z,     B2, A1)); // 20
      tbl.push_back(row(5'b01000, 32'h24, Z,      Z,     Z,   5'b10000, Z,      Z,     R1, A1)); // 21 ack
      tbl.push_back(row(5'b01000, 32'h24, Z,      Z,     Z,   5'b00001, Z,      Z,     R1, A1)); // 22 inelig
      tbl.push_back(row(5'b01001, 32'h24, Z,      Z,     R2,  5'b00101, 32'h24, Z,     R1, A1)); // 23
      tbl.push_back(row(5'b00000, Z,      Z,      Z,     Z,   5'b10000, Z,      Z,     R2, A1)); // 24
      tbl.push_back(row(5'b00110, Z,      32'h80, 32'h55,Z,   5'b00001, Z,      Z,     R2, A1)); // 25 store
      tbl.push_back(row(5'b00110, Z,      32'h80, 32'h55,Z,   5'b00111, 32'h80, 32'h55,R2, A1)); // 26
      tbl.push_back(row(5'b10110, Z,      32'h80, 32'h55,Z,   5'b00001, Z,      Z,     Z,  Z));  // 27 rst
      tbl.push_back(row(5'b00001, Z,      Z,      Z,     XX,  5'b00000, Z,      Z,     Z,  Z));  // 28 stray rdy
      tbl.push_back(row(5'b00000, Z,      Z,      Z,     Z,   5'b00000, Z,      Z,     Z,  Z));  // 29
      tbl.push_back(row(5'b00100, Z,      32'h84, Z,     Z,   5'b00001, Z,      Z,     Z,  Z));  // 30 load
      tbl.push_back(row(5'b00101, Z,      32'h84, Z,     CF,  5'b00101, 32'h84, Z,     Z,  Z));  // 31
      tbl.push_back(row(5'b00100, Z,      32'h84, Z,     Z,   5'b01000, Z,      Z,     Z,  CF)); // 32
      tbl.push_back(row(5'b00000, Z,      Z,      Z,     Z,   5'b00000, Z,      Z,     Z,  CF)); // 33

      foreach (tbl[k]) begin
         @(posedge clk); #1;
         rst       = tbl[k].inb[4];
         i_req     = tbl[k].inb[3];
         d_req     = tbl[k].inb[2];
         d_we      = tbl[k].inb[1];
         mem_ready = tbl[k].inb[0];
         i_addr    = tbl[k].iaddr;
         d_addr    = tbl[k].daddr;
         d_wdata   = tbl[k].dwdata;
         mem_rdata = tbl[k].mrdata;
         @(negedge clk);
         chk1 ("i_ack",   k, i_ack,   tbl[k].exb[4]);
         chk1 ("d_ack",   k, d_ack,   tbl[k].exb[3]);
         chk1 ("mem_req", k, mem_req, tbl[k].exb[2]);
         chk1 ("stall",   k, stall,   tbl[k].exb[0]);
         chk32("i_rdata", k, i_rdata, tbl[k].irdata);
         chk32("d_rdata", k, d_rdata, tbl[k].drdata);
         if (tbl[k].exb[2] || tbl[k].inb[4]) begin
            chk1 ("mem_we",   k, mem_we,   tbl[k].exb[1]);
            chk32("mem_addr", k, mem_addr, tbl[k].maddr);
         end
         if (tbl[k].exb[1] || tbl[k].inb[4]) begin
            chk32("mem_wdata", k, mem_wdata, tbl[k].mwdata);
         end
      end

      // Tie-break sequences: restart from reset so the last-grant state is known.
      @(posedge clk); #1;
      rst = 1'b1; i_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      lone(1'b1, 32'h500, 32'h5555_0001, 100);
      tie(TIE_AFTER_D_FIRST_D, 101);
      lone(1'b0, 32'h600, 32'h6666_0001, 102);
      tie(1'b1, 103);
      @(posedge clk); #1;
      chk1("final_idle_req", 104, mem_req, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-ported instruction/data memory between the processor's instruction-fetch path (I) and its load/store path (D, driven by the memread/memwrite decode). Grants one requester at a time, holds the memory request until the memory signals completion, and returns read data with a one-cycle acknowledge. Raises a stall to the processor while any request is outstanding.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- i_req  in  1  fetch request, held until i_ack
- i_addr  in  ADDR_W  fetch address, stable while i_req
- i_ack  out  1  one-cycle fetch completion pulse
- i_rdata  out  DATA_W  fetched word, valid with i_ack, held until next I completion
- d_req  in  1  load/store request, held until d_ack
- d_we  in  1  1 = store, 0 = load; stable while d_req
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_ack  out  1  one-cycle data completion pulse
- d_rdata  out  DATA_W  load data, valid with d_ack, held until next D load completion
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  write enable to memory
- mem_addr  out  ADDR_W  registered address
- mem_wdata  out  DATA_W  registered write data
- mem_ready  in  1  memory completion, sampled only while mem_req
- mem_rdata  in  DATA_W  read data, valid with mem_ready
- stall  out  1  (i_req & ~i_ack) | (d_req & ~d_ack)

## Operation
- States: ARB_IDLE, ARB_BUSY_I, ARB_BUSY_D.
- ARB_IDLE: pick among eligible requesters; requester whose ack is high this cycle is ineligible. Grant registers mem_addr/mem_we/mem_wdata (mem_we=0 for I), sets mem_req, moves to BUSY_I/BUSY_D. No eligible request: stay.
- Priority without macro: D wins over I (older instruction).
- BUSY_x: hold mem_* stable. On mem_ready: capture mem_rdata into x_rdata (not for stores), pulse x_ack next cycle, drop mem_req, return to ARB_IDLE.
- Requester dropping req before ack: transaction still completes and acks; bench flags it as protocol violation.
- mem_ready while mem_req=0: ignored.
- Reset values: state ARB_IDLE; i_ack, d_ack, mem_req, mem_we = 0; mem_addr, mem_wdata, i_rdata, d_rdata = 0.
- Reset mid-transaction: all above forced immediately; pending transaction abandoned, no ack ever issued for it.

## Timing
- Cycle 0: req seen in IDLE. Cycle 1: mem_req high. Cycle k≥1: mem_ready. Cycle k+1: x_ack, x_rdata valid, state IDLE.
- Minimum req-to-ack latency 2 cycles (mem_ready in cycle 1).
- In ack cycle the other requester may be granted (mem_req again in next cycle); same requester re-eligible the cycle after its ack.
- stall combinational from inputs and registered acks; falls in ack cycle.

## Configuration
- MEM_ARB_RR_EN defined: when both eligible in IDLE, grant the one not granted last; last-grant register resets to I (so D wins first tie). Single eligible requester always granted.
- Undefined: fixed D-over-I priority; no last-grant register.

## Structure
- mem_arb_pkg: state enum (ARB_IDLE, ARB_BUSY_I, ARB_BUSY_D), grant-id constants GNT_I/GNT_D.
- One sub-module natural: mem_arb_pick, combinational selector (eligible vectors + last grant -> grant id), holding the MEM_ARB_RR_EN difference.

## Test plan
- Single fetch i_addr=0x10, mem_ready in cycle 1, mem_rdata=0x8C010004 -> i_ack cycle 2, i_rdata=0x8C010004, mem_we=0, stall low in cycle 2.
- Store d_addr=0x40, d_wdata=0xDEADBEEF, mem_ready delayed 3 cycles -> mem_req/mem_we/mem_addr/mem_wdata stable 3 cycles, d_ack cycle 5, d_rdata unchanged.
- i_req and d_req together, both held -> D first; second grant I; with MEM_ARB_RR_EN repeated ties alternate D,I,D,I; without it D,D while d_req kept high starves I.
- Back-to-back: i_req held across i_ack -> second fetch mem_req asserts 2 cycles after first i_ack cycle (one ineligible cycle, then grant).
- rst pulsed during BUSY_D -> mem_req, d_ack, mem_we 0 at once; no ack after release; next request served normally.
- mem_ready pulsed while idle -> no ack, state stays ARB_IDLE.
